audio_level_reader: RTL and testbench

AUDIO_LEVEL_READER -- requirements
Module: audio_level_reader

---
 rtl/audio_level_reader.sv | 128 ++++++++++++
 tb/tb_audio_level_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_reader.sv
// audio_level_reader
// Pops stereo samples from the audio controller input FIFO, tracks the
// largest per-sample magnitude over a fixed window of samples, and
// publishes that window level together with a peak-hold value and a
// loudness flag. Each sample is handled by a three-state
// IDLE -> READ -> ACC sequence, so a read never follows a read directly.
module audio_level_reader #(
    parameter int unsigned WINDOW       = 4800,
    parameter int unsigned THRESHOLD    = 64,
    parameter int unsigned HOLD_WINDOWS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        audio_in_available,
    input  logic [31:0] left_in,
    input  logic [31:0] right_in,
    output logic        read_out,
    output logic [7:0]  level,
    output logic [7:0]  peak,
    output logic        loud_flag,
    output logic        window_done
);

    localparam int unsigned CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned HOLD_W = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINDOWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACC
    } state_t;

    state_t             state;
    logic [31:0]        cap_left;
    logic [31:0]        cap_right;
    logic [7:0]         win_max;
    logic [CNT_W-1:0]   sample_cnt;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [7:0]         mag_left;
    logic [7:0]         mag_right;
    logic [7:0]         mag_sample;
    logic [7:0]         win_next;

    // Absolute value with the most negative code saturated to the most
    // positive one, then scaled down to its top eight magnitude bits.
    function automatic logic [7:0] mag8(input logic [31:0] s);
        logic [31:0] a;
        if (s == 32'h8000_0000)
            a = 32'h7FFF_FFFF;
        else if (s[31])
            a = -s;
        else
            a = s;
        // a[31] is always 0 here, so the 8-bit truncation yields a[30:23]
        return 8'(a >> 23);
    endfunction

    // Magnitude of the captured sample and the running window maximum it produces
    always_comb begin
        mag_left   = mag8(cap_left);
        mag_right  = mag8(cap_right);
        mag_sample = (mag_left > mag_right) ? mag_left : mag_right;
        win_next   = (mag_sample > win_max) ? mag_sample : win_max;
    end

    // Read sequencer, window accumulation and level/peak publication
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            read_out    <= 1'b0;
            window_done <= 1'b0;
            loud_flag   <= 1'b0;
            level       <= '0;
            peak        <= '0;
            win_max     <= '0;
            sample_cnt  <= '0;
            hold_cnt    <= '0;
            cap_left    <= '0;
            cap_right   <= '0;
        end else begin
            read_out    <= 1'b0;
            window_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && audio_in_available) begin
                        state    <= READ;
                        read_out <= 1'b1;
                    end
                end
                READ: begin
                    cap_left  <= left_in;
                    cap_right <= right_in;
                    state     <= ACC;
                end
                ACC: begin
                    state <= IDLE;
                    if (sample_cnt == CNT_LAST) begin
                        level       <= win_next;
                        loud_flag   <= (32'(win_next) >= THRESHOLD);
                        window_done <= 1'b1;
                        win_max     <= '0;
                        sample_cnt  <= '0;
                        // Peak follows rising levels at once; a lower level
                        // only replaces it after the hold count expires.
                        if (win_next >= peak) begin
                            peak     <= win_next;
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            peak     <= win_next;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        win_max    <= win_next;
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_level_reader.sv
// Directed testbench for audio_level_reader.
// Instance a: WINDOW=4, THRESHOLD=64, HOLD_WINDOWS=5.
// Instance b: WINDOW=2, THRESHOLD=64, HOLD_WINDOWS=2.
module tb_audio_level_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a;
    logic        en_b;
    logic        avail;
    logic [31:0] left;
    logic [31:0] right;

    logic        read_out_a, loud_a, wd_a;
    logic [7:0]  level_a, peak_a;
    logic        read_out_b, loud_b, wd_b;
    logic [7:0]  level_b, peak_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    audio_level_reader #(.WINDOW(4), .THRESHOLD(64), .HOLD_WINDOWS(5)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .audio_in_available(avail),
        .left_in(left), .right_in(right), .read_out(read_out_a),
        .level(level_a), .peak(peak_a), .loud_flag(loud_a), .window_done(wd_a)
    );

    audio_level_reader #(.WINDOW(2), .THRESHOLD(64), .HOLD_WINDOWS(2)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .audio_in_available(avail),
        .left_in(left), .right_in(right), .read_out(read_out_b),
        .level(level_b), .peak(peak_b), .loud_flag(loud_b), .window_done(wd_b)
    );

    // Sample whose 8-bit magnitude is exactly v
    function automatic logic [31:0] mk(input logic [7:0] v);
        return {1'b0, v, 23'd0};
    endfunction

    // Push one sample through IDLE/READ/ACC; returns one cycle after ACC.
    // Availability drops during ACC, which must not disturb the sample.
    task automatic feed(input int which, input logic [31:0] l, input logic [31:0] r);
        left  = l;
        right = r;
        avail = 1'b1;
        if (which == 0) en_a = 1'b1; else en_b = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        en_b = 1'b0;
        @(posedge clk); #1;
        avail = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({read_out_a, wd_a, loud_a, level_a, peak_a} !== 19'd0)
            $display("FAIL reset_a: got %h expected 0", {read_out_a, wd_a, loud_a, level_a, peak_a}); else passed++;
        total++; if ({read_out_b, wd_b, loud_b, level_b, peak_b} !== 19'd0)
            $display("FAIL reset_b: got %h expected 0", {read_out_b, wd_b, loud_b, level_b, peak_b}); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_cadence();
        int pops = 0;
        logic exp_rd;
        logic exp_wd;
        left  = 32'h4000_0000;
        right = 32'h0;
        avail = 1'b1;
        en_a  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            exp_rd = (k % 3 == 1) && (k <= 10);
            exp_wd = (k == 12);
            if (read_out_a === 1'b1) pops++;
            total++; if (read_out_a !== exp_rd)
                $display("FAIL cadence_read_out k=%0d: got %b expected %b", k, read_out_a, exp_rd); else passed++;
            total++; if (wd_a !== exp_wd)
                $display("FAIL cadence_window_done k=%0d: got %b expected %b", k, wd_a, exp_wd); else passed++;
            if (k == 11) begin
                total++; if (level_a !== 8'h00)
                    $display("FAIL cadence_level_early: got %h expected 00", level_a); else passed++;
            end
            if (k == 10) en_a = 1'b0;
        end
        total++; if (pops !== 4)
            $display("FAIL cadence_pops: got %0d expected 4", pops); else passed++;
        total++; if (level_a !== 8'h80)
            $display("FAIL cadence_level: got %h expected 80", level_a); else passed++;
        total++; if (loud_a !== 1'b1)
            $display("FAIL cadence_loud: got %b expected 1", loud_a); else passed++;
        total++; if (peak_a !== 8'h80)
            $display("FAIL cadence_peak: got %h expected 80", peak_a); else passed++;
    endtask

    task automatic test_most_negative();
        for (int i = 0; i < 3; i++) feed(0, 32'h8000_0000, 32'h0);
        total++; if ({wd_a, level_a} !== {1'b0, 8'h80})
            $display("FAIL neg_partial: got %b/%h expected 0/80", wd_a, level_a); else passed++;
        feed(0, 32'h8000_0000, 32'h0);
        total++; if (level_a !== 8'hFF)
            $display("FAIL neg_level: got %h expected ff", level_a); else passed++;
        total++; if (wd_a !== 1'b1)
            $display("FAIL neg_window_done: got %b expected 1", wd_a); else passed++;
        total++; if (peak_a !== 8'hFF)
            $display("FAIL neg_peak: got %h expected ff", peak_a); else passed++;
        @(posedge clk); #1;
        total++; if (wd_a !== 1'b0)
            $display("FAIL neg_window_done_pulse: got %b expected 0", wd_a); else passed++;
    endtask

    task automatic test_channel_max();
        feed(0, mk(8'h10), 32'h0);
        feed(0, 32'h0, -mk(8'h60));
        feed(0, -mk(8'h20), mk(8'h08));
        feed(0, mk(8'h05), -mk(8'h05));
        total++; if (level_a !== 8'h60)
            $display("FAIL chmax_level: got %h expected 60", level_a); else passed++;
        total++; if (loud_a !== 1'b1)
            $display("FAIL chmax_loud: got %b expected 1", loud_a); else passed++;
        total++; if (peak_a !== 8'hFF)
            $display("FAIL chmax_peak_held: got %h expected ff", peak_a); else passed++;
    endtask

    task automatic test_hold();
        logic [7:0] lv [4];
        logic [7:0] pk [4];
        lv = '{8'd200, 8'd10, 8'd10, 8'd10};
        pk = '{8'd200, 8'd200, 8'd10, 8'd10};
        for (int w = 0; w < 4; w++) begin
            feed(1, mk(lv[w]), 32'h0);
            feed(1, 32'h0, 32'h0);
            total++; if ({wd_b, level_b} !== {1'b1, lv[w]})
                $display("FAIL hold_level w=%0d: got %b/%0d expected 1/%0d", w, wd_b, level_b, lv[w]); else passed++;
            total++; if (peak_b !== pk[w])
                $display("FAIL hold_peak w=%0d: got %0d expected %0d", w, peak_b, pk[w]); else passed++;
        end
    endtask

    task automatic test_threshold();
        feed(1, 32'h0, mk(8'd63));
        feed(1, 32'h0, 32'h0);
        total++; if ({level_b, loud_b} !== {8'd63, 1'b0})
            $display("FAIL thresh_63: got %0d/%b expected 63/0", level_b, loud_b); else passed++;
        feed(1, -mk(8'd64), 32'h0);
        feed(1, 32'h0, 32'h0);
        total++; if ({level_b, loud_b} !== {8'd64, 1'b1})
            $display("FAIL thresh_64: got %0d/%b expected 64/1", level_b, loud_b); else passed++;
    endtask

    task automatic test_reset_mid();
        feed(0, mk(8'h70), 32'h0);
        feed(0, mk(8'h70), 32'h0);
        left  = mk(8'h70);
        right = 32'h0;
        avail = 1'b1;
        en_a  = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        @(posedge clk); #1;
        total++; if (level_a !== 8'h60)
            $display("FAIL rmid_pre_level: got %h expected 60", level_a); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if ({read_out_a, wd_a, loud_a, level_a, peak_a} !== 19'd0)
            $display("FAIL rmid_clear_a: got %h expected 0", {read_out_a, wd_a, loud_a, level_a, peak_a}); else passed++;
        total++; if ({read_out_b, wd_b, loud_b, level_b, peak_b} !== 19'd0)
            $display("FAIL rmid_clear_b: got %h expected 0", {read_out_b, wd_b, loud_b, level_b, peak_b}); else passed++;
        for (int i = 0; i < 3; i++) begin
            feed(0, mk(8'h50), 32'h0);
            total++; if ({wd_a, level_a} !== 9'd0)
                $display("FAIL rmid_fresh i=%0d: got %b/%h expected 0/00", i, wd_a, level_a); else passed++;
        end
        feed(0, mk(8'h50), 32'h0);
        total++; if ({wd_a, level_a, loud_a, peak_a} !== {1'b1, 8'h50, 1'b1, 8'h50})
            $display("FAIL rmid_window: got %b/%h/%b/%h expected 1/50/1/50", wd_a, level_a, loud_a, peak_a); else passed++;
    endtask

    task automatic test_enable_gate();
        left  = mk(8'h22);
        right = 32'h0;
        avail = 1'b1;
        en_a  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++; if (read_out_a !== 1'b0)
                $display("FAIL gate_idle k=%0d: got %b expected 0", k, read_out_a); else passed++;
        end
        en_a = 1'b1;
        @(posedge clk); #1;
        total++; if (read_out_a !== 1'b1)
            $display("FAIL gate_resume: got %b expected 1", read_out_a); else passed++;
        en_a = 1'b0;
        @(posedge clk); #1;
        total++; if (read_out_a !== 1'b0)
            $display("FAIL gate_no_b2b: got %b expected 0", read_out_a); else passed++;
        @(posedge clk); #1;
        total++; if ({wd_a, level_a} !== {1'b0, 8'h50})
            $display("FAIL gate_partial: got %b/%h expected 0/50", wd_a, level_a); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        avail = 1'b0;
        left  = '0;
        right = '0;
        test_reset();
        test_cadence();
        test_most_negative();
        test_channel_max();
        test_hold();
        test_threshold();
        test_reset_mid();
        test_enable_gate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
